// File: rtl/icmp_seq.sv
// icmp_seq: a multi-cycle wide-integer comparator. It compares the operand
// pair one CW-bit chunk per cycle, starting at the most significant chunk,
// and returns the full set of signed and unsigned relational flags.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds a/b/in_valid until that edge, and the
// consumer sees the flags qualified by out_valid. in_ready is high only in
// IDLE and out_valid only in DONE, so input and output never overlap in the
// same cycle.
module icmp_seq #(
  parameter int BW         = 64,
  parameter int CW         = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          eq,
  output logic          ne,
  output logic          slt,
  output logic          sle,
  output logic          sgt,
  output logic          sge,
  output logic          ult,
  output logic          ule,
  output logic          ugt,
  output logic          uge,
  output logic [1:0]    dbg_state
);

  localparam int NCHUNK = BW / CW;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [BW-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic          differ, lt_u;
  logic [CW-1:0] a_ch, b_ch;
  logic          differ_nx, ltu_nx, last, accept, sgn;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Select the chunk currently addressed by idx from both captured operands.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_ch = a_r[i*CW +: CW];
        b_ch = b_r[i*CW +: CW];
      end
    end
  end

  // The first differing chunk decides the unsigned ordering; later chunks
  // never overwrite it. 'last' marks the final RUN cycle of a transaction.
  always_comb begin
    differ_nx = differ | (a_ch != b_ch);
    ltu_nx    = differ ? lt_u : (a_ch < b_ch);
    last      = (idx == '0) || ((EARLY_EXIT != 0) && differ_nx);
    sgn       = a_r[BW-1] ^ b_r[BW-1];
  end

  // Next-state logic for the IDLE -> RUN -> DONE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Operand capture and chunk walk; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r    <= a;
      b_r    <= b;
      idx    <= IW'(NCHUNK - 1);
      differ <= 1'b0;
      lt_u   <= 1'b0;
    end else if (state == S_RUN) begin
      differ <= differ_nx;
      lt_u   <= ltu_nx;
      if (!last) idx <= idx - 1'b1;
    end
  end

  // Result flags, registered once at the RUN -> DONE transition. The sign
  // correction only matters when a difference exists: equal operands share
  // their top bit, so sgn is zero in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      {eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge} <= '0;
    end else if ((state == S_RUN) && last) begin
      eq  <= ~differ_nx;
      ne  <= differ_nx;
      ult <= ltu_nx;
      uge <= ~ltu_nx;
      ugt <= differ_nx & ~ltu_nx;
      ule <= ~(differ_nx & ~ltu_nx);
      slt <= ltu_nx ^ sgn;
      sge <= ~(ltu_nx ^ sgn);
      sgt <= (differ_nx & ~ltu_nx) ^ sgn;
      sle <= ~((differ_nx & ~ltu_nx) ^ sgn);
    end
  end

endmodule

// File: tb/tb_icmp_seq.sv
// Bench for icmp_seq: one early-exit instance and one full-walk instance
// share the operand buses; 'sel' chooses which one the tasks drive.
module tb_icmp_seq;

  localparam int W = 16;  // {latency[5:0], flags[9:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv  = 1'b0;
  logic        ordy = 1'b0;
  logic        sel = 1'b1;
  logic [63:0] a_bus = '0;
  logic [63:0] b_bus = '0;

  logic        ir0, ir1, ov0, ov1;
  logic [9:0]  fl0, fl1;
  logic [1:0]  st0, st1;
  logic        ir, ov;
  logic [9:0]  fl;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  assign ir = sel ? ir1 : ir0;
  assign ov = sel ? ov1 : ov0;
  assign fl = sel ? fl1 : fl0;

  icmp_seq #(.BW(64), .CW(8), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir1),
    .a(a_bus), .b(b_bus), .out_valid(ov1), .out_ready(ordy & sel),
    .eq(fl1[9]), .ne(fl1[8]), .slt(fl1[7]), .sle(fl1[6]), .sgt(fl1[5]),
    .sge(fl1[4]), .ult(fl1[3]), .ule(fl1[2]), .ugt(fl1[1]), .uge(fl1[0]),
    .dbg_state(st1)
  );

  icmp_seq #(.BW(64), .CW(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir0),
    .a(a_bus), .b(b_bus), .out_valid(ov0), .out_ready(ordy & ~sel),
    .eq(fl0[9]), .ne(fl0[8]), .slt(fl0[7]), .sle(fl0[6]), .sgt(fl0[5]),
    .sge(fl0[4]), .ult(fl0[3]), .ule(fl0[2]), .ugt(fl0[1]), .uge(fl0[0]),
    .dbg_state(st0)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference flags straight from the SystemVerilog relational operators.
  function automatic logic [9:0] model_flags(input logic [63:0] x, input logic [63:0] y);
    return {x == y, x != y,
            $signed(x) <  $signed(y), $signed(x) <= $signed(y),
            $signed(x) >  $signed(y), $signed(x) >= $signed(y),
            x < y, x <= y, x > y, x >= y};
  endfunction

  // Reference latency: chunks walked down to the highest differing byte.
  function automatic int model_lat(input logic [63:0] x, input logic [63:0] y, input bit ee);
    if (!ee) return 8;
    for (int i = 7; i >= 0; i--) begin
      if (x[i*8 +: 8] != y[i*8 +: 8]) return 8 - i;
    end
    return 8;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present one operand pair, handshake, optionally log
  // the expected result.
  task automatic do_accept(input logic [63:0] x, input logic [63:0] y, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir) check("accept_timeout", {63'd0, ir}, 64'd1);
    a_bus = x;
    b_bus = y;
    iv    = 1'b1;
    @(posedge clk);
    #1;
    iv    = 1'b0;
    a_bus = {$urandom, $urandom};
    b_bus = {$urandom, $urandom};
    if (push) exp_q.push_back({6'(model_lat(x, y, sel)), model_flags(x, y)});
  endtask

  // Count cycles from the handshake edge to out_valid, then compare the
  // latency and flags against the oldest expected entry. Ends at a negedge.
  task automatic do_result(input string tag);
    int n = 0;
    logic [W-1:0] e;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ov) break;
    end
    check({tag, "_valid"}, {63'd0, ov}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_latency"}, 64'(n), 64'(e[15:10]));
      check({tag, "_flags"}, {54'd0, fl}, {54'd0, e[9:0]});
    end
  endtask

  // Accept the result and confirm the block returns to IDLE.
  task automatic do_out_hs(input string tag);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    @(negedge clk);
    check({tag, "_ov_low"}, {63'd0, ov}, 64'd0);
    check({tag, "_ir_high"}, {63'd0, ir}, 64'd1);
  endtask

  task automatic txn(input string tag, input logic [63:0] x, input logic [63:0] y);
    do_accept(x, y, 1'b1);
    do_result(tag);
    do_out_hs(tag);
  endtask

  initial begin
    logic [9:0]  held;
    logic [63:0] ra, rb;
    int k;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ir1", {63'd0, ir1}, 64'd0);
    check("rst_ir0", {63'd0, ir0}, 64'd0);
    check("rst_ov", {62'd0, ov1, ov0}, 64'd0);
    check("rst_flags", {44'd0, fl1, fl0}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ir", {62'd0, ir1, ir0}, 64'd3);

    // Directed cases on the early-exit build
    sel = 1'b1;
    txn("equal", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    txn("top", 64'h8000000000000000, 64'h0000000000000001);
    txn("bottom", 64'hFFFFFFFFFFFFFF05, 64'hFFFFFFFFFFFFFF07);
    txn("zero_vs_max", 64'h0, 64'hFFFFFFFFFFFFFFFF);

    // Random pairs differing in one random chunk (or equal)
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      k  = $urandom_range(0, 8);
      rb = ra;
      if (k < 8) rb[k*8 +: 8] = ra[k*8 +: 8] ^ 8'($urandom_range(1, 255));
      txn("rand", ra, rb);
    end

    // Full-walk build
    sel = 1'b0;
    txn("ee0_top", 64'h8000000000000000, 64'h0000000000000001);
    txn("ee0_keep", 64'h1000000000000000, 64'h0FFFFFFFFFFFFFFF);
    sel = 1'b1;

    // Backpressure with a new pair waiting on the input
    do_accept(64'h8000000000000000, 64'h0000000000000001, 1'b1);
    do_result("bp");
    held  = fl;
    a_bus = 64'd5;
    b_bus = 64'd3;
    iv    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ov_hold", {63'd0, ov}, 64'd1);
      check("bp_ir_hold", {63'd0, ir}, 64'd0);
      check("bp_flags_hold", {54'd0, fl}, {54'd0, held});
    end
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    @(negedge clk);
    check("bp_ir_rise", {63'd0, ir}, 64'd1);
    check("bp_ov_fall", {63'd0, ov}, 64'd0);
    @(posedge clk);
    #1 iv = 1'b0;
    exp_q.push_back({6'(model_lat(64'd5, 64'd3, 1'b1)), model_flags(64'd5, 64'd3)});
    do_result("bp_next");
    do_out_hs("bp_next");

    // Reset three cycles into an equal-operand transaction
    do_accept(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_ir_low", {63'd0, ir}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ov", {63'd0, ov}, 64'd0);
    check("midrst_flags", {54'd0, fl}, 64'd0);
    check("midrst_ir", {63'd0, ir}, 64'd1);
    txn("after_rst", 64'd5, 64'd3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icmp_seq.md
Name: icmp_seq

Overview:
- Multi-cycle wide-integer comparison controller.
- Accepts one operand pair per transaction and walks the operands MSB-chunk-first through a CW-bit comparator slice. Stops early on the first differing chunk.
- Returns the full flag set: eq, ne, signed and unsigned lt/le/gt/ge.
- Sits between an operand producer and a result consumer. Uses valid/ready handshakes on both sides, trading latency for a narrow comparator.

Parameters:
- BW, 64, operand width in bits; BW % CW == 0 required.
- CW, 8, chunk width compared per cycle; 1 <= CW <= BW.
- EARLY_EXIT, 1, 1 = finish on first unequal chunk; 0 = always process all NCHUNK = BW/CW chunks.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  BW  operand A; sampled only on input handshake.
- b  input  BW  operand B; sampled only on input handshake.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer accepts result.
- eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge  output  1 each  comparison flags, same semantics as $signed / unsigned SV operators on a, b.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; out_valid=0; all ten flags=0.
  - Captured operands and chunk index are don't-care.
  - in_ready=0 while rst is high, and 1 from the first cycle after rst deasserts.
  - Reset mid-RUN or mid-DONE abandons the transaction; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into registers; set idx=NCHUNK-1; clear the "differ" flag; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, compare captured chunk idx (bits idx*CW+CW-1 : idx*CW) of a and b.
  - If the chunks are unequal and no earlier chunk differed: record differ=1 and lt_u = (a_chunk < b_chunk, unsigned).
  - If differ && EARLY_EXIT, or idx==0: go to DONE and register the flags. Otherwise decrement idx.
  - Later chunks never overwrite a recorded difference (relevant when EARLY_EXIT=0).
- Flag computation at the RUN→DONE transition:
  - s = a[BW-1]^b[BW-1].
  - eq = ~differ; ne = differ.
  - ult = lt_u; ugt = differ & ~lt_u; ule = ~ugt; uge = ~ult.
  - slt = ult ^ s; sgt = ugt ^ s; sle = ~sgt; sge = ~slt.
  - s is 0 whenever differ is 0, so eq implies slt=sgt=0.
- Latency:
  - k = number of chunks processed. With EARLY_EXIT=1, k = 1 + (NCHUNK-1 - index of highest differing chunk), or NCHUNK if equal. With EARLY_EXIT=0, k = NCHUNK.
  - out_valid rises k cycles after the input handshake edge.
  - NCHUNK=1 gives a fixed latency of 1.
- DONE:
  - out_valid=1; in_ready=0.
  - Flags held stable while out_ready=0, for any number of cycles.
  - On out_valid&&out_ready: out_valid=0 next cycle; go to IDLE.
  - in_ready rises the cycle after the output handshake; no same-cycle input/output overlap.
- Flags:
  - Registered; change only at the RUN→DONE transition or reset.
  - Retain their last values in IDLE/RUN, but are qualified only by out_valid.
- Input stability: a/b may change after the input handshake without affecting the result. in_valid during RUN/DONE is ignored and not consumed.

Test Plan (BW=64, CW=8):
- Equal operands: a=b=0x0123456789ABCDEF, EARLY_EXIT=1 -> out_valid 8 cycles after accept. eq=ule=uge=sle=sge=1; all other flags 0.
- Top-chunk difference: a=0x8000000000000000, b=0x0000000000000001 -> latency 1. ne=ugt=uge=slt=sle=1; eq=ult=ule=sgt=sge=0.
- Bottom-chunk difference: a=0xFFFFFFFFFFFFFF05, b=0xFFFFFFFFFFFFFF07 -> latency 8. ne=ult=ule=slt=sle=1; ugt=uge=sgt=sge=eq=0.
- EARLY_EXIT=0 build, same stimulus as the top-chunk case -> latency 8, identical flags. Also a=0x10..00, b=0x0F..FF -> ugt=sgt=1, not corrupted by the later lower chunks.
- Backpressure: complete the top-chunk case with out_ready=0 for 5 cycles while in_valid=1 with new operands -> flags and out_valid stable, in_ready=0, new operands not consumed. Raise out_ready -> in_ready=1 next cycle. The new pair is then accepted and produces its own correct result.
- Reset mid-RUN: assert rst for 1 cycle 3 cycles into the equal-operands case -> out_valid=0 and flags=0 after the reset edge, in_ready=1 the cycle after. A following transaction a=5, b=3 yields ugt=sgt=1 with latency 8.
